// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM state encoding and
// operation-select constants.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/sumador_restador_serial_digit.sv
// N-bit ripple adder with carry in/out; used as the per-digit adder of the
// serial unit. Purely combinational.
module sumadorNbits #(
  parameter int N = 2
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, c_i};

endmodule

// File: rtl/sumador_restador_serial.sv
// Digit-serial unsigned add/subtract, D bits per cycle, result N/D+2 cycles after start.
// Define SUMADOR_RESTADOR_OVF_EN to add the OvfFlag (signed overflow) output.
module sumador_restador_serial
  import alu_pkg::*;
#(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] aIn,
  input  logic [N-1:0] bIn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] cOut,
  output logic         NegFlag,
  output logic         ZeroFlag,
`ifdef SUMADOR_RESTADOR_OVF_EN
  output logic         CarryFlag,
  output logic         OvfFlag
`else
  output logic         CarryFlag
`endif
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           mode_q, mode_d, carry_q, carry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   res_q, res_d;
  logic           res_neg_q, res_neg_d, res_carry_q, res_carry_d;
  logic [N-1:0]   cout_q, cout_d;
  logic           neg_q, neg_d, zero_q, zero_d, cflag_q, cflag_d, done_q, done_d;

  logic [D-1:0]   a_dig, b_dig, s_dig;
  logic           c_dig;
  logic [N-1:0]   s_ext;

  assign a_dig = a_q[D-1:0];
  assign b_dig = (mode_q == MODE_SUB) ? ~b_q[D-1:0] : b_q[D-1:0];

  sumadorNbits #(.N(D)) u_digit (
    .a_i(a_dig),
    .b_i(b_dig),
    .c_i(carry_q),
    .s_o(s_dig),
    .c_o(c_dig)
  );

  always_comb begin
    s_ext = '0;
    s_ext[D-1:0] = s_dig;
  end

`ifdef SUMADOR_RESTADOR_OVF_EN
  logic ovf_raw_q, ovf_raw_d, ovf_q, ovf_d;
  logic c_msb;

  // Carry into the digit MSB recovered from its sum bit.
  assign c_msb = a_dig[D-1] ^ b_dig[D-1] ^ s_dig[D-1];

  always_comb begin
    ovf_raw_d = ovf_raw_q;
    ovf_d     = ovf_q;
    if (state_q == CALC) ovf_raw_d = c_msb ^ c_dig;
    if (state_q == DONE) ovf_d = ovf_raw_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_raw_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_raw_q <= ovf_raw_d;
      ovf_q     <= ovf_d;
    end
  end

  assign OvfFlag = ovf_q;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    res_neg_d   = res_neg_q;
    res_carry_d = res_carry_q;
    cout_d      = cout_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    cflag_d     = cflag_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = aIn;
          b_d     = bIn;
          mode_d  = mode;
          carry_d = (mode == MODE_SUB);
          sum_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Operands shift right; result digits enter at the top, LSB digit first.
        a_d     = a_q >> D;
        b_d     = b_q >> D;
        sum_d   = (sum_q >> D) | (s_ext << (N - D));
        carry_d = c_dig;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        if (mode_q == MODE_ADD || carry_q) begin
          res_d       = sum_q;
          res_neg_d   = 1'b0;
          res_carry_d = carry_q;
        end else begin
          res_d       = '0 - sum_q;
          res_neg_d   = 1'b1;
          res_carry_d = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        cout_d  = res_q;
        neg_d   = res_neg_q;
        cflag_d = res_carry_q;
        zero_d  = (res_q == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      mode_q      <= MODE_ADD;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      res_neg_q   <= 1'b0;
      res_carry_q <= 1'b0;
      cout_q      <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b1;
      cflag_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      res_neg_q   <= res_neg_d;
      res_carry_q <= res_carry_d;
      cout_q      <= cout_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      cflag_q     <= cflag_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cOut      = cout_q;
  assign NegFlag   = neg_q;
  assign ZeroFlag  = zero_q;
  assign CarryFlag = cflag_q;

endmodule

// File: tb/tb_sumador_restador_serial.sv
// Bench for sumador_restador_serial at N=8 with D in {1,2,4,8}; define
// SUMADOR_RESTADOR_OVF_EN to also check OvfFlag.
module tb_sumador_restador_serial;

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       neg;
    logic       zero;
    logic       carry;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s [4];
  logic       mode_s  [4];
  logic [7:0] a_s     [4];
  logic [7:0] b_s     [4];
  logic       busy_s  [4];
  logic       done_s  [4];
  logic [7:0] cout_s  [4];
  logic       neg_s   [4];
  logic       zero_s  [4];
  logic       carry_s [4];
`ifdef SUMADOR_RESTADOR_OVF_EN
  logic       ovf_s   [4];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sumador_restador_serial #(.N(8), .D(1 << g)) u_dut (
      .clk(clk),
      .rst(rst),
      .start(start_s[g]),
      .mode(mode_s[g]),
      .aIn(a_s[g]),
      .bIn(b_s[g]),
      .busy(busy_s[g]),
      .done(done_s[g]),
      .cOut(cout_s[g]),
      .NegFlag(neg_s[g]),
      .ZeroFlag(zero_s[g]),
`ifdef SUMADOR_RESTADOR_OVF_EN
      .CarryFlag(carry_s[g]),
      .OvfFlag(ovf_s[g])
`else
      .CarryFlag(carry_s[g])
`endif
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done; inputs are scrambled right
  // after the sampling edge so a missing operand latch shows up.
  task automatic run_op(input int k, input logic m, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output bit ok);
    @(negedge clk);
    mode_s[k] = m; a_s[k] = a; b_s[k] = b; start_s[k] = 1'b1;
    @(posedge clk);
    #1;
    start_s[k] = 1'b0; a_s[k] = ~a; b_s[k] = a ^ b; mode_s[k] = ~m;
    lat = 0;
    ok  = 1'b0;
    while (lat < 30 && !ok) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_s[k]) ok = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs[10];
    int   lat;
    bit   ok;
    bit   saw_done;
    int   k;
    string tag;

    vecs[0] = '{1'b0, 8'd200, 8'd100, 8'd44,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 8'd5,   8'd9,   8'd4,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'd9,   8'd9,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'd100, 8'd100, 8'd200, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'd255, 8'd1,   8'd0,   1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 8'd0,   8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'd200, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 8'd127, 8'd1,   8'd128, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0; mode_s[i] = 1'b0; a_s[i] = 8'd0; b_s[i] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("D%0d", 1 << i);
      check({tag, " reset busy"},  busy_s[i],  0);
      check({tag, " reset done"},  done_s[i],  0);
      check({tag, " reset cOut"},  cout_s[i],  0);
      check({tag, " reset neg"},   neg_s[i],   0);
      check({tag, " reset zero"},  zero_s[i],  1);
      check({tag, " reset carry"}, carry_s[i], 0);
`ifdef SUMADOR_RESTADOR_OVF_EN
      check({tag, " reset ovf"},   ovf_s[i],   0);
`endif
    end
    rst = 1'b0;

    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < 10; i++) begin
        tag = $sformatf("D%0d vec%0d", 1 << d, i);
        run_op(d, vecs[i].m, vecs[i].a, vecs[i].b, lat, ok);
        check({tag, " done seen"}, ok, 1);
        check({tag, " latency"},   lat, 8 / (1 << d) + 2);
        check({tag, " cOut"},      cout_s[d],  vecs[i].c);
        check({tag, " neg"},       neg_s[d],   vecs[i].neg);
        check({tag, " zero"},      zero_s[d],  vecs[i].zero);
        check({tag, " carry"},     carry_s[d], vecs[i].carry);
`ifdef SUMADOR_RESTADOR_OVF_EN
        check({tag, " ovf"},       ovf_s[d],   vecs[i].ovf);
`endif
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, done_s[d], 0);
        check({tag, " cOut hold"},        cout_s[d], vecs[i].c);
      end
    end

    // Start pulse and operand changes mid-calculation must be ignored.
    k = 1;
    @(negedge clk);
    mode_s[k] = 1'b1; a_s[k] = 8'd5; b_s[k] = 8'd9; start_s[k] = 1'b1;
    @(posedge clk);
    #1 start_s[k] = 1'b0;
    @(posedge clk);
    #1;
    check("busy in CALC", busy_s[k], 1);
    start_s[k] = 1'b1; mode_s[k] = 1'b0; a_s[k] = 8'd77; b_s[k] = 8'd3;
    @(posedge clk);
    #1 start_s[k] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (done_s[k]) ok = 1'b1;
    end
    check("ignored start done seen", ok, 1);
    check("ignored start cOut", cout_s[k], 4);
    check("ignored start neg",  neg_s[k],  1);
    repeat (3) @(posedge clk);
    #1;
    check("no queued op busy", busy_s[k], 0);

    // Abort in the second CALC cycle.
    @(negedge clk);
    mode_s[k] = 1'b0; a_s[k] = 8'd200; b_s[k] = 8'd100; start_s[k] = 1'b1;
    @(posedge clk);
    #1 start_s[k] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", busy_s[k], 0);
    check("abort cOut", cout_s[k], 0);
    check("abort done", done_s[k], 0);
    check("abort zero", zero_s[k], 1);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_s[k]) saw_done = 1'b1;
    end
    check("abort no done", saw_done, 0);

    // rst and start together: start is lost.
    @(negedge clk);
    rst = 1'b1; start_s[k] = 1'b1; mode_s[k] = 1'b0; a_s[k] = 8'd1; b_s[k] = 8'd1;
    @(posedge clk);
    #1 rst = 1'b0; start_s[k] = 1'b0;
    @(posedge clk);
    #1;
    check("rst+start busy", busy_s[k], 0);
    run_op(k, 1'b0, 8'd3, 8'd4, lat, ok);
    check("post-reset done seen", ok, 1);
    check("post-reset latency", lat, 6);
    check("post-reset cOut", cout_s[k], 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sumador_restador_serial.md
SUMADOR_RESTADOR_SERIAL -- requirements
Module: sumador_restador_serial

Interface
REQ-001 Parameter N, default 8: operand and result width in bits.
REQ-002 Parameter D, default 2: digit width in bits processed per cycle; N SHALL be an integer multiple of D, with D in 1..N.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 mode  input  1  operation select: 0 = add, 1 = subtract.
REQ-007 aIn  input  N  operand A, unsigned.
REQ-008 bIn  input  N  operand B, unsigned.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when the result registers update.
REQ-011 cOut  output  N  result: sum modulo 2^N, or difference magnitude.
REQ-012 NegFlag  output  1  high when a subtraction gave A<B.
REQ-013 ZeroFlag  output  1  high when cOut==0.
REQ-014 CarryFlag  output  1  add: carry out of bit N-1; subtract: high when A>=B (no borrow).

Function
REQ-015 FSM states SHALL be IDLE, CALC, FIX and DONE.
  - IDLE->CALC on start=1.
  - CALC->FIX after N/D cycles.
  - FIX->DONE after 1 cycle.
  - DONE->IDLE after 1 cycle.
REQ-016 On start in IDLE, aIn, bIn and mode SHALL be latched; later input changes SHALL NOT affect the operation.
REQ-017 CALC SHALL process one D-bit digit per cycle, LSB digit first, carrying between digits in a 1-bit carry register.
  - Carry initialised to 0 for add, 1 for subtract.
  - B digit inverted for subtract.
REQ-018 FIX, add mode: result = raw sum; NegFlag=0; CarryFlag = final carry.
REQ-019 FIX, subtract with final carry=1: result = raw difference; NegFlag=0; CarryFlag=1.
REQ-020 FIX, subtract with final carry=0: result = two's complement of the raw difference (B-A); NegFlag=1; CarryFlag=0.
REQ-021 cOut and all flags SHALL update together in DONE, with done=1 for exactly that cycle.
REQ-022 cOut and flags SHALL hold their values until the next DONE.
REQ-023 Latency SHALL be N/D+2 cycles from the start-sampling edge to done high, i.e. 6 cycles for N=8, D=2.
REQ-024 start SHALL be ignored in CALC, FIX and DONE; there is no queuing, and back-to-back operations need start in IDLE.
REQ-025 Arithmetic SHALL be modulo 2^N, with no other saturation or exception.

Reset
REQ-026 rst=1 SHALL force IDLE on the next edge from any state, aborting any operation in progress.
REQ-027 Reset values SHALL be: busy=0, done=0, cOut=0, NegFlag=0, ZeroFlag=1, CarryFlag=0, carry register 0, digit counter 0.
REQ-028 If rst and start are both high in the same cycle, rst SHALL win and the start SHALL be lost.

Configuration
REQ-029 Macro SUMADOR_RESTADOR_OVF_EN defined: extra output port OvfFlag (1 bit), the two's-complement signed overflow of the raw A±B.
  - Computed as carry-in XOR carry-out of the MSB in the final digit.
  - Updated in DONE, reset to 0.
REQ-030 Macro SUMADOR_RESTADOR_OVF_EN undefined: the OvfFlag port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package alu_pkg SHALL hold:
  - the state enum (IDLE, CALC, FIX, DONE);
  - mode constants MODE_ADD=1'b0 and MODE_SUB=1'b1.
REQ-032 The digit adder SHALL be one instance of the existing sumadorNbits with N=D; the module holds the FSM, shift registers, counter and result/flag registers.

Verification (N=8, D=2)
REQ-033 Add: mode=0, A=200, B=100 -> done exactly 6 cycles after start; cOut=44, CarryFlag=1, NegFlag=0, ZeroFlag=0.
REQ-034 Subtract, negative: mode=1, A=5, B=9 -> cOut=4, NegFlag=1, CarryFlag=0, ZeroFlag=0.
REQ-035 Subtract, equal: mode=1, A=9, B=9 -> cOut=0, ZeroFlag=1, CarryFlag=1, NegFlag=0.
REQ-036 Busy/reset: start pulse and operand changes during CALC are ignored and the first result is correct; rst asserted in the 2nd CALC cycle -> next cycle IDLE, busy=0, cOut=0, no done pulse.
REQ-037 With SUMADOR_RESTADOR_OVF_EN: mode=0, A=100, B=100 -> cOut=200, OvfFlag=1; mode=1, A=0x80, B=0x01 -> OvfFlag=1.
REQ-038 Parameter sweep: D in {1,2,4,8}; random operands against a reference model; latency N/D+2 in every case.
